conf_cmd_decoder: RTL and testbench

CONF_CMD_DECODER -- requirements
Module: conf_cmd_decoder

---
 rtl/conf_cmd_decoder.sv | 189 ++++++++++++++++++
 tb/tb_conf_cmd_decoder.sv | 493 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conf_cmd_decoder.sv
// -----------------------------------------------------------------------------
// conf_cmd_decoder
//
// Decodes a byte stream into configuration register writes and read-all
// requests.
//
// Frames:
//   write    : cmd (bit7=1, bits[6:0]=address), data low byte, data high byte
//   read-all : cmd (bit7=0), single byte
//
// A read-all sets a pending flag. The shift-out stage is told to snapshot and
// send the registers with a one-cycle request pulse as soon as it is not busy.
// A frame that stalls for TIMEOUT cycles between bytes is dropped and flagged
// with err. A write to an address at or above NUM_REGS is also dropped and
// flagged with err.
//
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous, active-high reset
//   rx_data    received byte, valid while rx_rdy=1
//   rx_rdy     one-cycle strobe per received byte
//   tx_busy    shift-out stage is currently sending
//   registers  flat register array, register i at [16i+15:16i]
//   request    one-cycle pulse: snapshot and send registers
//   err        one-cycle pulse: bad address or inter-byte timeout
//   busy       a frame is partially received
// -----------------------------------------------------------------------------
module conf_cmd_decoder #(
    parameter int NUM_REGS   = 20,
    parameter int DATA_WIDTH = 16,
    parameter int RX_WIDTH   = 8,
    parameter int TIMEOUT    = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [RX_WIDTH-1:0]            rx_data,
    input  logic                           rx_rdy,
    input  logic                           tx_busy,
    output logic [DATA_WIDTH*NUM_REGS-1:0] registers,
    output logic                           request,
    output logic                           err,
    output logic                           busy
);

    localparam int               GAP_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [GAP_W-1:0] GAP_MAX   = GAP_W'(TIMEOUT - 1);
    localparam logic [6:0]       REG_LIMIT = 7'(NUM_REGS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA_LO,
        ST_DATA_HI
    } state_t;

    state_t                          state_q, state_d;
    logic [6:0]                      addr_q;
    logic [7:0]                      lo_q;
    logic [GAP_W-1:0]                gap_q, gap_d;
    logic                            pending_q, pending_d;
    logic                            err_q, err_d;
    logic [DATA_WIDTH*NUM_REGS-1:0]  regs_q;

    logic load_addr;
    logic load_lo;
    logic wr_fire;
    logic wr_en;
    logic rd_cmd;
    logic timeout;
    logic addr_ok;

    // -------------------------------------------------------------------------
    // Next-state and output decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        load_addr = 1'b0;
        load_lo   = 1'b0;
        wr_fire   = 1'b0;
        rd_cmd    = 1'b0;
        timeout   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_rdy) begin
                    if (rx_data[7]) begin
                        load_addr = 1'b1;
                        state_d   = ST_DATA_LO;
                    end else begin
                        rd_cmd = 1'b1;
                    end
                end
            end
            ST_DATA_LO: begin
                // A byte arriving in the expiry cycle still counts.
                if (rx_rdy) begin
                    load_lo = 1'b1;
                    state_d = ST_DATA_HI;
                end else if (gap_q == GAP_MAX) begin
                    timeout = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DATA_HI: begin
                if (rx_rdy) begin
                    wr_fire = 1'b1;
                    state_d = ST_IDLE;
                end else if (gap_q == GAP_MAX) begin
                    timeout = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        addr_ok = (addr_q < REG_LIMIT);
        wr_en   = wr_fire && addr_ok;
        err_d   = (wr_fire && !addr_ok) || timeout;

        // Gap counter only runs while a frame is open.
        if (rx_rdy || (state_q == ST_IDLE) || timeout) begin
            gap_d = '0;
        end else begin
            gap_d = gap_q + GAP_W'(1);
        end

        // The pulse is taken straight from the pending flag so a read-all
        // with tx_busy low is answered in the very next cycle. A read-all
        // arriving while pending (including the pulse cycle) merges, which
        // also keeps request from firing on two consecutive cycles.
        request = pending_q && !tx_busy;
        if (pending_q) begin
            pending_d = !request;
        end else begin
            pending_d = rd_cmd;
        end

        busy = (state_q != ST_IDLE);
    end

    // -------------------------------------------------------------------------
    // Control state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            lo_q      <= '0;
            gap_q     <= '0;
            pending_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the
            // pre-edge values regardless of statement order.
            state_q   <= state_d;
            gap_q     <= gap_d;
            pending_q <= pending_d;
            err_q     <= err_d;
            if (load_addr) begin
                addr_q <= rx_data[6:0];
            end
            if (load_lo) begin
                lo_q <= rx_data[7:0];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Register file
    // -------------------------------------------------------------------------
    // NOTE: the register file is in the reset domain on purpose; downstream
    // logic relies on all-zero configuration after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (addr_q == 7'(i)) begin
                    regs_q[i*DATA_WIDTH +: DATA_WIDTH] <= {rx_data[7:0], lo_q};
                end
            end
        end
    end

    assign registers = regs_q;
    assign err       = err_q;

endmodule

// File: tb/tb_conf_cmd_decoder.sv
// -----------------------------------------------------------------------------
// tb_conf_cmd_decoder
//
// Scoreboard bench for conf_cmd_decoder. Scenario tasks push expected register
// writes, err pulses and request pulses into queues as they drive bytes; a
// monitor pops them when the DUT produces the corresponding output. Each task
// also checks timing of its own scenario inline.
// -----------------------------------------------------------------------------
module tb_conf_cmd_decoder;

    localparam int NUM_REGS = 20;
    localparam int TIMEOUT  = 1024;
    localparam int FLAT_W   = 16 * NUM_REGS;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        rx_data;
    logic              rx_rdy;
    logic              tx_busy;
    logic [FLAT_W-1:0] registers;
    logic              request;
    logic              err;
    logic              busy;

    conf_cmd_decoder #(
        .NUM_REGS   (NUM_REGS),
        .DATA_WIDTH (16),
        .RX_WIDTH   (8),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_rdy    (rx_rdy),
        .tx_busy   (tx_busy),
        .registers (registers),
        .request   (request),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [15:0] data;
    } wr_t;

    int                vectors     = 0;
    int                miscompares = 0;
    wr_t               wr_q[$];
    string             err_exp[$];
    string             req_exp[$];
    logic [15:0]       model [NUM_REGS];
    logic [FLAT_W-1:0] prev_regs;
    logic              req_prev;
    wr_t               mon_e;
    string             mon_s;

    function automatic logic [FLAT_W-1:0] model_flat();
        logic [FLAT_W-1:0] f;
        for (int i = 0; i < NUM_REGS; i++) begin
            f[i*16 +: 16] = model[i];
        end
        return f;
    endfunction

    // ------------------------------------------------------------------
    // Monitor: pops expectations when the DUT produces output
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        #1;
        if (rst) begin
            prev_regs = registers;
            req_prev  = 1'b0;
        end else begin
            if (registers !== prev_regs) begin
                vectors++;
                if (wr_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL reg_change: registers=%h, expected unchanged %h", registers, prev_regs);
                end else begin
                    mon_e = wr_q.pop_front();
                    model[mon_e.addr] = mon_e.data;
                    if (registers !== model_flat()) begin
                        miscompares++;
                        $display("FAIL reg_write[%0d]: registers=%h, expected %h", mon_e.addr, registers, model_flat());
                    end
                end
                prev_regs = registers;
            end
            if (err) begin
                vectors++;
                if (err_exp.size() == 0) begin
                    miscompares++;
                    $display("FAIL err_pulse: err=1, expected 0 (no error due)");
                end else begin
                    mon_s = err_exp.pop_front();
                end
            end
            if (request) begin
                vectors++;
                if (req_exp.size() == 0) begin
                    miscompares++;
                    $display("FAIL request_pulse: request=1, expected 0 (no request due)");
                end else begin
                    mon_s = req_exp.pop_front();
                end
                vectors++;
                if (req_prev) begin
                    miscompares++;
                    $display("FAIL request_consecutive: request=1 two cycles running, expected single-cycle pulse");
                end
            end
            req_prev = request;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (drive only)
    // ------------------------------------------------------------------
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_rdy  = 1'b1;
        @(negedge clk);
        rx_rdy  = 1'b0;
        rx_data = '0;
    endtask

    // Up to four strobes on consecutive cycles.
    task automatic send_burst(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3,
                              input int n);
        logic [7:0] b [4];
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_data = b[i];
            rx_rdy  = 1'b1;
        end
        @(negedge clk);
        rx_rdy  = 1'b0;
        rx_data = '0;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst     = 1'b1;
        rx_rdy  = 1'b0;
        rx_data = '0;
        tx_busy = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (registers !== '0) begin
            miscompares++;
            $display("FAIL reset_registers: got %h, expected 0", registers);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy: got %b, expected 0", busy);
        end
        vectors++;
        if (request !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_request: got %b, expected 0", request);
        end
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_err: got %b, expected 0", err);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_write();
        int          addrs [4] = '{3, 0, 19, 7};
        logic [15:0] vals  [4] = '{16'h1234, 16'hBEEF, 16'h8001, 16'h00FF};
        for (int k = 0; k < 4; k++) begin
            send_byte({1'b1, 7'(addrs[k])});
            #1;
            vectors++;
            if (busy !== 1'b1) begin
                miscompares++;
                $display("FAIL write_busy[%0d]: got %b, expected 1", addrs[k], busy);
            end
            send_byte(vals[k][7:0]);
            wr_q.push_back('{addrs[k], vals[k]});
            send_byte(vals[k][15:8]);
            #1;
            vectors++;
            if (registers[addrs[k]*16 +: 16] !== vals[k]) begin
                miscompares++;
                $display("FAIL write_value[%0d]: got %h, expected %h", addrs[k], registers[addrs[k]*16 +: 16], vals[k]);
            end
            vectors++;
            if (busy !== 1'b0 || err !== 1'b0) begin
                miscompares++;
                $display("FAIL write_done[%0d]: busy=%b err=%b, expected 0 0", addrs[k], busy, err);
            end
        end
        repeat (2) @(negedge clk);
        #2;
        vectors++;
        if (wr_q.size() + err_exp.size() + req_exp.size() != 0) begin
            miscompares++;
            $display("FAIL write_drain: pending wr=%0d err=%0d req=%0d, expected 0", wr_q.size(), err_exp.size(), req_exp.size());
        end
    endtask

    task automatic test_bad_addr();
        logic [7:0] cmds [2] = '{8'h94, 8'hFF};
        for (int k = 0; k < 2; k++) begin
            send_byte(cmds[k]);
            send_byte(8'hAA);
            err_exp.push_back("bad_addr");
            send_byte(8'hBB);
            #1;
            vectors++;
            if (err !== 1'b1) begin
                miscompares++;
                $display("FAIL bad_addr_err[%h]: got %b, expected 1", cmds[k], err);
            end
            @(negedge clk);
            #1;
            vectors++;
            if (err !== 1'b0) begin
                miscompares++;
                $display("FAIL bad_addr_err_width[%h]: got %b, expected 0", cmds[k], err);
            end
        end
        repeat (2) @(negedge clk);
        #2;
        vectors++;
        if (wr_q.size() + err_exp.size() + req_exp.size() != 0) begin
            miscompares++;
            $display("FAIL bad_addr_drain: pending wr=%0d err=%0d req=%0d, expected 0", wr_q.size(), err_exp.size(), req_exp.size());
        end
    endtask

    task automatic test_read_all();
        // Not busy: pulse in the cycle right after the command.
        req_exp.push_back("read_all_idle");
        send_byte(8'h00);
        #1;
        vectors++;
        if (request !== 1'b1) begin
            miscompares++;
            $display("FAIL read_all_next_cycle: got %b, expected 1", request);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (request !== 1'b0) begin
            miscompares++;
            $display("FAIL read_all_single: got %b, expected 0", request);
        end
        // Busy for 10 cycles: pulse on the first free cycle.
        @(negedge clk);
        tx_busy = 1'b1;
        req_exp.push_back("read_all_busy");
        send_byte(8'h7F);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            vectors++;
            if (request !== 1'b0) begin
                miscompares++;
                $display("FAIL read_all_held[%0d]: got %b, expected 0", c, request);
            end
        end
        @(negedge clk);
        tx_busy = 1'b0;
        #1;
        vectors++;
        if (request !== 1'b1) begin
            miscompares++;
            $display("FAIL read_all_release: got %b, expected 1", request);
        end
        repeat (3) @(negedge clk);
        #2;
        vectors++;
        if (wr_q.size() + err_exp.size() + req_exp.size() != 0) begin
            miscompares++;
            $display("FAIL read_all_drain: pending wr=%0d err=%0d req=%0d, expected 0", wr_q.size(), err_exp.size(), req_exp.size());
        end
    endtask

    task automatic test_merge();
        @(negedge clk);
        tx_busy = 1'b1;
        req_exp.push_back("merged");
        send_byte(8'h00);
        send_byte(8'h12);
        send_byte(8'h40);
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (request !== 1'b0) begin
            miscompares++;
            $display("FAIL merge_while_busy: got %b, expected 0", request);
        end
        @(negedge clk);
        tx_busy = 1'b0;
        #1;
        vectors++;
        if (request !== 1'b1) begin
            miscompares++;
            $display("FAIL merge_release: got %b, expected 1", request);
        end
        repeat (4) @(negedge clk);
        #2;
        vectors++;
        if (wr_q.size() + err_exp.size() + req_exp.size() != 0) begin
            miscompares++;
            $display("FAIL merge_drain: pending wr=%0d err=%0d req=%0d, expected 0", wr_q.size(), err_exp.size(), req_exp.size());
        end
    endtask

    task automatic test_back_to_back();
        // Read-all then a full write on consecutive cycles while busy.
        @(negedge clk);
        tx_busy = 1'b1;
        req_exp.push_back("b2b_read");
        wr_q.push_back('{10, 16'hF00D});
        send_burst(8'h00, 8'h8A, 8'h0D, 8'hF0, 4);
        #1;
        vectors++;
        if (registers[10*16 +: 16] !== 16'hF00D) begin
            miscompares++;
            $display("FAIL b2b_write: got %h, expected f00d", registers[10*16 +: 16]);
        end
        vectors++;
        if (request !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_busy_request: got %b, expected 0", request);
        end
        @(negedge clk);
        tx_busy = 1'b0;
        #1;
        vectors++;
        if (request !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_release: got %b, expected 1", request);
        end
        repeat (3) @(negedge clk);
        // Second read-all lands in the pulse cycle and must merge.
        req_exp.push_back("b2b_merge");
        send_burst(8'h00, 8'h00, 8'h00, 8'h00, 2);
        #1;
        vectors++;
        if (request !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_no_second_pulse: got %b, expected 0", request);
        end
        repeat (3) @(negedge clk);
        #2;
        vectors++;
        if (wr_q.size() + err_exp.size() + req_exp.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_drain: pending wr=%0d err=%0d req=%0d, expected 0", wr_q.size(), err_exp.size(), req_exp.size());
        end
    endtask

    task automatic test_timeout();
        // Stall in the high-byte state for TIMEOUT cycles.
        send_byte(8'h81);
        send_byte(8'h55);
        err_exp.push_back("timeout");
        repeat (TIMEOUT - 1) @(negedge clk);
        #1;
        vectors++;
        if (busy !== 1'b1 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_early: busy=%b err=%b, expected 1 0", busy, err);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0 || err !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_abort: busy=%b err=%b, expected 0 1", busy, err);
        end
        vectors++;
        if (registers[1*16 +: 16] !== 16'h0000) begin
            miscompares++;
            $display("FAIL timeout_no_write: got %h, expected 0000", registers[1*16 +: 16]);
        end
        wr_q.push_back('{1, 16'h0001});
        send_byte(8'h81);
        send_byte(8'h01);
        send_byte(8'h00);
        #1;
        vectors++;
        if (registers[1*16 +: 16] !== 16'h0001) begin
            miscompares++;
            $display("FAIL timeout_recover: got %h, expected 0001", registers[1*16 +: 16]);
        end
        // Low byte arriving in the expiry cycle is accepted.
        wr_q.push_back('{5, 16'h7766});
        send_byte(8'h85);
        repeat (TIMEOUT - 2) @(negedge clk);
        send_byte(8'h66);
        #1;
        vectors++;
        if (busy !== 1'b1 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_edge_byte: busy=%b err=%b, expected 1 0", busy, err);
        end
        send_byte(8'h77);
        #1;
        vectors++;
        if (registers[5*16 +: 16] !== 16'h7766) begin
            miscompares++;
            $display("FAIL timeout_edge_write: got %h, expected 7766", registers[5*16 +: 16]);
        end
        repeat (2) @(negedge clk);
        #2;
        vectors++;
        if (wr_q.size() + err_exp.size() + req_exp.size() != 0) begin
            miscompares++;
            $display("FAIL timeout_drain: pending wr=%0d err=%0d req=%0d, expected 0", wr_q.size(), err_exp.size(), req_exp.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        send_byte(8'h82);
        send_byte(8'h11);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
        #1;
        vectors++;
        if (registers !== '0) begin
            miscompares++;
            $display("FAIL midreset_registers: got %h, expected 0", registers);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_busy: got %b, expected 0", busy);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wr_q.push_back('{2, 16'h3322});
        send_byte(8'h82);
        send_byte(8'h22);
        send_byte(8'h33);
        #1;
        vectors++;
        if (registers[2*16 +: 16] !== 16'h3322) begin
            miscompares++;
            $display("FAIL midreset_write: got %h, expected 3322", registers[2*16 +: 16]);
        end
        repeat (2) @(negedge clk);
        #2;
        vectors++;
        if (wr_q.size() + err_exp.size() + req_exp.size() != 0) begin
            miscompares++;
            $display("FAIL midreset_drain: pending wr=%0d err=%0d req=%0d, expected 0", wr_q.size(), err_exp.size(), req_exp.size());
        end
    endtask

    // ------------------------------------------------------------------
    // Sequencer and watchdog
    // ------------------------------------------------------------------
    initial begin
        rst = 1'b1;
        test_reset();
        test_write();
        test_bad_addr();
        test_read_all();
        test_merge();
        test_back_to_back();
        test_timeout();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
